// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, default line timing and bit-period derivation.
package uart_pkg;

  localparam int DEFAULT_CLK_FREQ  = 50_000_000;
  localparam int DEFAULT_BAUD_RATE = 115_200;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Truncating division: the line runs marginally fast rather than slow.
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter; bit_tick marks the last clock cycle of each bit.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk_50M,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign bit_tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, LSB first, registered glitch-free tx line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (11-bit frame).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE    = DEFAULT_BAUD_RATE,
  parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE)
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic [7:0] data,
  output logic       tx,
  output logic       tx_done
);

  uart_state_t state, state_next;
  logic [7:0]  shift_reg, shift_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic        parity_bit, parity_next;
  logic        tx_next, done_next;
  logic        bit_tick;

  // Counter is held cleared in IDLE so every frame starts on a fresh bit period.
  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk_50M  (clk_50M),
    .rst_n    (rst_n),
    .clr      (state == IDLE),
    .en       (state != IDLE),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_idx    <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      bit_idx    <= bit_idx_next;
      parity_bit <= parity_next;
      tx         <= tx_next;
      tx_done    <= done_next;
    end
  end

  always_comb begin
    state_next   = state;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx;
    parity_next  = parity_bit;
    done_next    = 1'b0;
    tx_next      = 1'b1;

    case (state)
      IDLE: begin
        if (tx_en) begin
          state_next   = START;
          shift_next   = data;
          parity_next  = ^data;
          bit_idx_next = '0;
        end
      end
      START: begin
        if (bit_tick) state_next = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shift_next   = shift_reg >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_tick) state_next = STOP;
      end
      STOP: begin
        if (bit_tick) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is decoded from the next state so tx changes on the same edge as the state.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and random checks of uart_tx via a scoreboarded line receiver model.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame.
module tb_uart_tx;

  localparam int C = 434;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk_50M;
  logic       rst_n;
  logic       tx_en;
  logic [7:0] data;
  logic       tx;
  logic       tx_done;

  int          check_count = 0;
  int          pass_count  = 0;
  int unsigned cyc = 0;
  int unsigned frame_starts[$];
  int unsigned done_cycles[$];
  int unsigned edges[$];
  logic [7:0]  exp_q[$];
  int          done_count = 0;
  int          done_width_err = 0;
  logic        rec_edges = 1'b0;
  logic        prev_tx = 1'b1;
  logic        prev_done = 1'b0;
  logic        rx_busy = 1'b0;
  int          rx_cnt = 0;
  int          rx_k;
  logic [7:0]  rx_byte = '0;
  logic [7:0]  rx_exp;
`ifdef UART_TX_PARITY_EN
  logic        rx_par = 1'b0;
`endif

  uart_tx dut (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .tx_en   (tx_en),
    .data    (data),
    .tx      (tx),
    .tx_done (tx_done)
  );

  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit push);
    @(posedge clk_50M);
    #1;
    data  = b;
    tx_en = 1'b1;
    if (push) exp_q.push_back(b);
    @(posedge clk_50M);
    #1;
    tx_en = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int start_count = done_count;
    int waited = 0;
    while (done_count == start_count && waited < budget) begin
      @(negedge clk_50M);
      #1;
      waited++;
    end
    checkOutput("done_within_budget", done_count != start_count, 1);
  endtask

  function automatic logic frame_level(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k < NB - 1) return ^b;
    return 1'b1;
  endfunction

  // Receiver model: samples mid-bit after each falling start edge and scores the decoded byte.
  always @(negedge clk_50M) begin
    cyc++;
    if (!rst_n) begin
      rx_busy   = 1'b0;
      prev_tx   = 1'b1;
      prev_done = 1'b0;
    end else begin
      if (tx_done) begin
        done_count++;
        done_cycles.push_back(cyc);
        if (prev_done) done_width_err++;
      end
      if (rec_edges && tx !== prev_tx) edges.push_back(cyc);
      if (!rx_busy && prev_tx && !tx) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
        frame_starts.push_back(cyc);
      end else if (rx_busy) begin
        rx_cnt++;
      end
      if (rx_busy && (rx_cnt % C) == C / 2) begin
        rx_k = rx_cnt / C;
        if (rx_k == 0) begin
          checkOutput("rx_start_bit", tx, 0);
        end else if (rx_k <= 8) begin
          rx_byte[rx_k-1] = tx;
`ifdef UART_TX_PARITY_EN
        end else if (rx_k == 9) begin
          rx_par = tx;
`endif
        end else begin
          checkOutput("rx_stop_bit", tx, 1);
          checkOutput("rx_sb_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            rx_exp = exp_q.pop_front();
            checkOutput("rx_byte", rx_byte, rx_exp);
`ifdef UART_TX_PARITY_EN
            checkOutput("rx_parity", rx_par, ^rx_exp);
`endif
          end
          rx_busy = 1'b0;
        end
      end
      prev_tx   = tx;
      prev_done = tx_done;
    end
  end

  int   base_starts, base_done, s, n_exp;
  int   exp_edges[$];
  logic cur_lvl;
  int   low_cnt;

  initial begin
    rst_n = 1'b0;
    tx_en = 1'b0;
    data  = '0;
    repeat (5) @(posedge clk_50M);
    #1;
    checkOutput("reset_tx", tx, 1);
    checkOutput("reset_tx_done", tx_done, 0);
    rst_n = 1'b1;

    low_cnt = 0;
    repeat (1000) begin
      @(negedge clk_50M);
      if (tx !== 1'b1) low_cnt++;
    end
    checkOutput("idle_line_high", low_cnt, 0);

    // Single 8'hA5 frame: edge timing against the line-level model.
    edges.delete();
    rec_edges   = 1'b1;
    base_starts = frame_starts.size();
    base_done   = done_count;
    applyStimulus(8'hA5, 1'b1);
    waitDone(NB * C + 50);
    rec_edges = 1'b0;
    checkOutput("a5_frame_started", frame_starts.size(), base_starts + 1);
    if (frame_starts.size() == base_starts + 1 && done_cycles.size() != 0) begin
      s = frame_starts[base_starts];
      checkOutput("a5_done_offset", done_cycles[done_cycles.size()-1] - s, NB * C);
      exp_edges.delete();
      cur_lvl = 1'b1;
      for (int k = 0; k < NB; k++) begin
        if (frame_level(8'hA5, k) != cur_lvl) begin
          exp_edges.push_back(k * C);
          cur_lvl = frame_level(8'hA5, k);
        end
      end
      checkOutput("a5_edge_count", edges.size(), exp_edges.size());
      n_exp = (edges.size() < exp_edges.size()) ? edges.size() : exp_edges.size();
      for (int i = 0; i < n_exp; i++) checkOutput("a5_edge_offset", edges[i] - s, exp_edges[i]);
    end
    repeat (2 * C) @(negedge clk_50M);
    checkOutput("a5_single_done", done_count, base_done + 1);

    // Back-to-back with tx_en held high; second byte loaded in the tx_done cycle.
    base_starts = frame_starts.size();
    base_done   = done_count;
    @(posedge clk_50M);
    #1;
    data  = 8'h00;
    tx_en = 1'b1;
    exp_q.push_back(8'h00);
    waitDone(NB * C + 50);
    data = 8'h7F;
    exp_q.push_back(8'h7F);
    waitDone(NB * C + 50);
    tx_en = 1'b0;
    repeat (2 * C) @(negedge clk_50M);
    checkOutput("b2b_frames", frame_starts.size() - base_starts, 2);
    checkOutput("b2b_dones", done_count - base_done, 2);
    if (frame_starts.size() >= base_starts + 2)
      checkOutput("b2b_period", frame_starts[base_starts+1] - frame_starts[base_starts], NB * C + 1);
    if (done_cycles.size() >= 2)
      checkOutput("b2b_done_spacing", done_cycles[done_cycles.size()-1] - done_cycles[done_cycles.size()-2], NB * C + 1);

    // Data and tx_en disturbed mid-frame must not alter the byte or start another frame.
    base_starts = frame_starts.size();
    base_done   = done_count;
    applyStimulus(8'h5A, 1'b1);
    repeat (3 * C) @(posedge clk_50M);
    #1;
    data  = 8'hFF;
    tx_en = 1'b1;
    repeat (5) @(posedge clk_50M);
    #1;
    tx_en = 1'b0;
    repeat (2 * C) @(posedge clk_50M);
    #1;
    data  = 8'h81;
    tx_en = 1'b1;
    @(posedge clk_50M);
    #1;
    tx_en = 1'b0;
    waitDone(NB * C + 50);
    repeat (2 * C) @(negedge clk_50M);
    checkOutput("midframe_no_extra_frame", frame_starts.size() - base_starts, 1);
    checkOutput("midframe_one_done", done_count - base_done, 1);

    // Reset during DATA aborts the frame; a clean 8'h3C frame follows.
    base_done = done_count;
    applyStimulus(8'hC3, 1'b0);
    repeat (3 * C) @(posedge clk_50M);
    #5;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_tx_async_high", tx, 1);
    checkOutput("abort_tx_done_low", tx_done, 0);
    repeat (3) @(posedge clk_50M);
    #1;
    rst_n = 1'b1;
    repeat (NB * C) @(negedge clk_50M);
    checkOutput("abort_no_done", done_count, base_done);
    applyStimulus(8'h3C, 1'b1);
    waitDone(NB * C + 50);

`ifdef UART_TX_PARITY_EN
    applyStimulus(8'h07, 1'b1);
    waitDone(NB * C + 50);
    applyStimulus(8'h03, 1'b1);
    waitDone(NB * C + 50);
`endif

    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'($urandom_range(0, 128)), 1'b1);
      waitDone(NB * C + 50);
    end

    repeat (10) @(negedge clk_50M);
    checkOutput("done_pulse_width", done_width_err, 0);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
